cache_refill_ctrl: RTL

Miss-handling side of the instruction/data cache replacement interface. It accepts a miss from the lookup stage and asks the replacement policy for a victim way. It then fetches the whole line from memory over a req/gnt/rvalid bus, writes the words into the data array, commits the tag, and pulses `taken` back to the policy. It sits between the cache lookup logic, the replacement policy and the memory port.

---
 rtl/cache_pkg.sv | 33 +++
 rtl/cache_addr_split.sv | 30 +++
 rtl/cache_refill_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared cache refill types and address-field width helpers.
// Used by the refill controller, the replacement policy and the lookup stage.
package cache_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_VICTIM,
      S_REQ,
      S_WAIT,
      S_COMMIT
   } refill_state_e;

   function automatic int byte_off_w(input int data_width);
      return $clog2(data_width / 8);
   endfunction

   function automatic int word_off_w(input int words_per_line);
      return $clog2(words_per_line);
   endfunction

   function automatic int index_w(input int set_count);
      return $clog2(set_count);
   endfunction

   function automatic int tag_w(input int addr_width,
                                input int data_width,
                                input int words_per_line,
                                input int set_count);
      return addr_width - byte_off_w(data_width)
           - word_off_w(words_per_line) - index_w(set_count);
   endfunction

endpackage

// File: rtl/cache_addr_split.sv
// Combinational split of a byte address into tag, set index and word offset.
// Shared by the lookup stage and the refill controller.
module cache_addr_split
   import cache_pkg::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int WORDS_PER_LINE = 4,
   parameter int SET_COUNT      = 64,
   localparam int BW = byte_off_w(DATA_WIDTH),
   localparam int OW = word_off_w(WORDS_PER_LINE),
   localparam int IW = index_w(SET_COUNT),
   localparam int TW = tag_w(ADDR_WIDTH, DATA_WIDTH, WORDS_PER_LINE, SET_COUNT)
) (
   input  logic [ADDR_WIDTH-1:0] addr_i,
   output logic [TW-1:0]         tag_o,
   output logic [IW-1:0]         index_o,
   output logic [OW-1:0]         word_o
);

   assign word_o  = addr_i[BW +: OW];
   assign index_o = addr_i[BW+OW +: IW];
   assign tag_o   = addr_i[ADDR_WIDTH-1 -: TW];

   if (BW > 0) begin : g_byte
      logic unused_byte;
      assign unused_byte = ^addr_i[BW-1:0];
   end

endmodule

// File: rtl/cache_refill_ctrl.sv
// Cache miss refill controller: victim request, line fetch, data/tag write.
// Define CACHE_CRITICAL_WORD_FIRST_EN to fetch the missing word first (adds crit_valid).
module cache_refill_ctrl
   import cache_pkg::*;
#(
   parameter int WAY_COUNT      = 2,
   parameter int SET_COUNT      = 64,
   parameter int WORDS_PER_LINE = 4,
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   localparam int BW = byte_off_w(DATA_WIDTH),
   localparam int OW = word_off_w(WORDS_PER_LINE),
   localparam int IW = index_w(SET_COUNT),
   localparam int WW = $clog2(WAY_COUNT),
   localparam int TW = tag_w(ADDR_WIDTH, DATA_WIDTH, WORDS_PER_LINE, SET_COUNT)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  miss_valid,
   output logic                  miss_ready,
   input  logic [ADDR_WIDTH-1:0] miss_addr,
   output logic [IW-1:0]         policy_set,
   input  logic [WW-1:0]         replacement_way,
   input  logic                  policy_ready,
   output logic                  policy_taken,
   output logic                  mem_req,
   input  logic                  mem_gnt,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic                  mem_rvalid,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  mem_err,
   output logic                  data_we,
   output logic [IW-1:0]         data_set,
   output logic [WW-1:0]         data_way,
   output logic [OW-1:0]         data_word,
   output logic [DATA_WIDTH-1:0] data_wdata,
   output logic                  tag_we,
   output logic [TW-1:0]         tag_value,
   output logic                  tag_valid,
   output logic                  refill_done,
   output logic                  refill_error
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
   ,
   output logic                  crit_valid
`endif
);

   refill_state_e state_q, state_d;
   logic [TW-1:0] tag_q, tag_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [WW-1:0] way_q, way_d;
   logic [OW-1:0] cnt_q, cnt_d;
   logic          err_q, err_d;
   logic          last_beat;

   logic [TW-1:0] s_tag;
   logic [IW-1:0] s_idx;
   logic [OW-1:0] s_word;

   cache_addr_split #(
      .ADDR_WIDTH    (ADDR_WIDTH),
      .DATA_WIDTH    (DATA_WIDTH),
      .WORDS_PER_LINE(WORDS_PER_LINE),
      .SET_COUNT     (SET_COUNT)
   ) u_split (
      .addr_i (miss_addr),
      .tag_o  (s_tag),
      .index_o(s_idx),
      .word_o (s_word)
   );

`ifdef CACHE_CRITICAL_WORD_FIRST_EN
   logic [OW-1:0] off_q, off_d;
   logic [OW-1:0] beat_q, beat_d;
   // Counter starts mid-line, so completion is tracked by beats, not address.
   assign last_beat = (beat_q == OW'(WORDS_PER_LINE - 1));
`else
   logic unused_word;
   assign unused_word = ^s_word;
   assign last_beat   = (cnt_q == OW'(WORDS_PER_LINE - 1));
`endif

   assign mem_addr   = ADDR_WIDTH'({tag_q, idx_q, cnt_q}) << BW;
   assign data_set   = idx_q;
   assign data_way   = way_q;
   assign data_word  = cnt_q;
   assign data_wdata = mem_rdata;
   assign tag_value  = tag_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         tag_q   <= '0;
         idx_q   <= '0;
         way_q   <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
         off_q   <= '0;
         beat_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         tag_q   <= tag_d;
         idx_q   <= idx_d;
         way_q   <= way_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
         off_q   <= off_d;
         beat_q  <= beat_d;
`endif
      end
   end

   always_comb begin
      state_d      = state_q;
      tag_d        = tag_q;
      idx_d        = idx_q;
      way_d        = way_q;
      cnt_d        = cnt_q;
      err_d        = err_q;
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
      off_d        = off_q;
      beat_d       = beat_q;
      crit_valid   = 1'b0;
`endif
      miss_ready   = 1'b0;
      policy_set   = idx_q;
      policy_taken = 1'b0;
      mem_req      = 1'b0;
      data_we      = 1'b0;
      tag_we       = 1'b0;
      tag_valid    = 1'b0;
      refill_done  = 1'b0;
      refill_error = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            // Held low while reset is asserted.
            miss_ready = reset_n;
            policy_set = s_idx;
            if (miss_valid) begin
               tag_d   = s_tag;
               idx_d   = s_idx;
               err_d   = 1'b0;
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
               off_d   = s_word;
`endif
               state_d = S_VICTIM;
            end
         end
         S_VICTIM: begin
            if (policy_ready) begin
               way_d   = replacement_way;
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
               cnt_d   = off_q;
               beat_d  = '0;
`else
               cnt_d   = '0;
`endif
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            mem_req = 1'b1;
            if (mem_gnt) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (mem_rvalid) begin
               if (mem_err) begin
                  err_d   = 1'b1;
                  state_d = S_COMMIT;
               end else begin
                  data_we = 1'b1;
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
                  crit_valid = (beat_q == '0);
                  beat_d     = beat_q + OW'(1);
`endif
                  if (last_beat) begin
                     state_d = S_COMMIT;
                  end else begin
                     cnt_d   = cnt_q + OW'(1);
                     state_d = S_REQ;
                  end
               end
            end
         end
         S_COMMIT: begin
            // Error path still writes the tag, to invalidate the torn way.
            tag_we       = 1'b1;
            tag_valid    = !err_q;
            policy_taken = !err_q;
            refill_done  = !err_q;
            refill_error = err_q;
            state_d      = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule
